// File: rtl/cdac_tx.sv
// cdac_tx: transmits frames of 'C','D','A','C' over a valid/ready byte bus, with idle gaps between frames.
// Optional feature macro CDAC_TX_ERR_INJ_EN adds an err_inj input that replaces 'A' with 'B' in each frame.
module cdac_tx #(
    parameter int          NFRAMES_W = 4,
    parameter int          GAP       = 2,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NFRAMES_W-1:0] nframes,
`ifdef CDAC_TX_ERR_INJ_EN
    input  logic                 err_inj,
`endif
    input  logic                 ready,
    output logic [7:0]           data,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam int GW = (GAP > 0) ? (($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1) : 1;
    localparam logic [NFRAMES_W-1:0] ONE_F = NFRAMES_W'(1);
    localparam logic [GW-1:0]        ONE_G = GW'(1);
    localparam logic [GW-1:0]        GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_C1   = 3'd1,
        S_D    = 3'd2,
        S_A    = 3'd3,
        S_C2   = 3'd4,
        S_GAP  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [NFRAMES_W-1:0] cnt_r, cnt_s;
    logic [GW-1:0]        gap_r, gap_s;
    logic                 err_r, err_s;
    logic [7:0]           data_s;
    logic                 valid_s;

    // Next-state logic; byte states advance only on an accepted transfer
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        gap_s   = gap_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    cnt_s = nframes;
`ifdef CDAC_TX_ERR_INJ_EN
                    err_s = err_inj;
`else
                    err_s = 1'b0;
`endif
                    if (nframes == {NFRAMES_W{1'b0}}) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_C1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            S_C1: begin
                if (ready) state_s = S_D; else state_s = S_C1;
            end
            S_D: begin
                if (ready) state_s = S_A; else state_s = S_D;
            end
            S_A: begin
                if (ready) state_s = S_C2; else state_s = S_A;
            end
            S_C2: begin
                if (ready) begin
                    cnt_s = cnt_r - ONE_F;
                    if (cnt_r == ONE_F) begin
                        state_s = S_DONE;
                    end else if (GAP > 0) begin
                        state_s = S_GAP;
                        gap_s   = GAP_LOAD;
                    end else begin
                        state_s = S_C1;
                    end
                end else begin
                    state_s = S_C2;
                end
            end
            S_GAP: begin
                if (gap_r == {GW{1'b0}}) begin
                    state_s = S_C1;
                end else begin
                    gap_s = gap_r - ONE_G;
                end
            end
            S_DONE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so data/valid can be registered with zero extra latency
    always_comb begin
        data_s  = IDLE_BYTE;
        valid_s = 1'b0;
        case (state_s)
            S_C1: begin valid_s = 1'b1; data_s = 8'd67; end
            S_D:  begin valid_s = 1'b1; data_s = 8'd68; end
            S_A:  begin valid_s = 1'b1; data_s = err_s ? 8'd66 : 8'd65; end
            S_C2: begin valid_s = 1'b1; data_s = 8'd67; end
            default: begin valid_s = 1'b0; data_s = IDLE_BYTE; end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {NFRAMES_W{1'b0}};
            gap_r   <= {GW{1'b0}};
            err_r   <= 1'b0;
            data    <= IDLE_BYTE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gap_r   <= gap_s;
            err_r   <= err_s;
            data    <= data_s;
            valid   <= valid_s;
            busy    <= (state_s != IDLE);
            done    <= (state_s == S_DONE);
        end
    end

endmodule

// File: tb/tb_cdac_tx.sv
// Scoreboard bench for cdac_tx: a frame-level model queues expected bytes, done pulses and cycle traces.
module tb_cdac_tx;
    localparam int NW = 4;
    localparam int GAP = 2;
    localparam logic [7:0] IDLE_B = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [NW-1:0] nframes = '0;
`ifdef CDAC_TX_ERR_INJ_EN
    logic          err_inj = 1'b0;
`endif
    logic [7:0]    data;
    logic          valid, busy, done;

    int total = 0;
    int passed = 0;
    logic [7:0]  exp_bytes[$];
    logic [10:0] trace_q[$];
    int  done_expected = 0;
    int  done_seen = 0;
    bit  mon_en = 1'b0;
    bit  bp_mode = 1'b0;

    cdac_tx #(.NFRAMES_W(NW), .GAP(GAP), .IDLE_BYTE(IDLE_B)) dut (
        .clk(clk), .rst(rst), .start(start), .nframes(nframes),
`ifdef CDAC_TX_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .ready(ready), .data(data), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: whole frames of bytes, gaps of GAP idle cycles, one done, then idle
    function automatic void push_request(input int n, input bit err);
        logic [7:0] frame[4];
        frame[0] = 8'd67; frame[1] = 8'd68; frame[2] = err ? 8'd66 : 8'd65; frame[3] = 8'd67;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(frame[b]);
                if (!bp_mode) trace_q.push_back({1'b1, 1'b1, 1'b0, frame[b]});
            end
            if (!bp_mode && f < n - 1)
                for (int g = 0; g < GAP; g++) trace_q.push_back({1'b1, 1'b0, 1'b0, IDLE_B});
        end
        if (!bp_mode) begin
            trace_q.push_back({1'b1, 1'b0, 1'b1, IDLE_B});
            trace_q.push_back({1'b0, 1'b0, 1'b0, IDLE_B});
        end
        done_expected++;
    endfunction

    // Monitor: compares against the scoreboard at the falling edge
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (valid && ready) begin
                if (exp_bytes.size() == 0) check("unexpected_byte", 32'(data), 32'hFFFF);
                else check("byte", 32'(data), 32'(exp_bytes.pop_front()));
            end
            if (!valid) check("idle_data", 32'(data), 32'(IDLE_B));
            if (done) begin
                check("done_expected", 32'(done_expected > 0), 32'd1);
                if (done_expected > 0) done_expected--;
                done_seen++;
            end
            if (trace_q.size() > 0)
                check("trace", 32'({busy, valid, done, data}), 32'(trace_q.pop_front()));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // spur: -1 none, -2 random starts while busy, k>=0 one start pulse k cycles into the request
    task automatic do_req(input int n, input bit err, input int spur);
        int ds0;
        int cyc;
        ds0 = done_seen;
        cyc = 0;
        start = 1'b1;
        nframes = NW'(n);
`ifdef CDAC_TX_ERR_INJ_EN
        err_inj = err;
`endif
        @(posedge clk);
        push_request(n, err);
        #1;
        start = 1'b0;
        nframes = NW'($urandom);
        while (done_seen == ds0 && cyc < 500) begin
            if (spur == -2) start = 1'($urandom_range(0, 1));
            else start = (spur == cyc);
            nframes = NW'($urandom_range(1, 15));
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("done_timeout", 32'(cyc < 500), 32'd1);
    endtask

    initial begin
        int vc;
        #12;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'(IDLE_B));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Reset asynchronously while S_D is on the bus
        start = 1'b1; nframes = NW'(2);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #3;
        check("pre_reset_data", 32'(data), 32'd68);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_data", 32'(data), 32'(IDLE_B));
        check("async_rst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b1;
        vc = 0;
        repeat (10) @(negedge clk) if (valid || busy) vc++;
        check("no_bytes_after_reset", 32'(vc), 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        do_req(1, 1'b0, -1);
        do_req(3, 1'b0, -1);
        do_req(0, 1'b0, -1);
        do_req(2, 1'b0, 2);
        do_req(15, 1'b0, -1);
        do_req(1, 1'b0, 0);

        bp_mode = 1'b1;
        for (int i = 0; i < 10; i++) do_req($urandom_range(0, 5), 1'($urandom_range(0, 1)) & err_ok(), -2);
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) do_req($urandom_range(0, 6), 1'($urandom_range(0, 1)) & err_ok(), -2);

        repeat (5) @(posedge clk);
        check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
        check("dones_drained", 32'(done_expected), 32'd0);
        check("trace_drained", 32'(trace_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic bit err_ok();
`ifdef CDAC_TX_ERR_INJ_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endmodule
